// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory bus between
// instruction fetch and the MEM-stage data port. One beat at a time, data
// has priority, each beat is watched by a timeout, and memory-wait
// stall/bubble requests are produced for the pipeline control.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                flush_fetch,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  // memory bus
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ready,
  input  logic [DATA_W-1:0]   bus_rdata,
  // pipeline control
  output logic                stall_front,
  output logic                stall_back,
  output logic                flush_D,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t              state_q,     state_d;
  logic                bus_req_q,   bus_req_d;
  logic                bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                discard_q,   discard_d;
  logic                err_q,       err_d;

  logic busy, beat_done, timed_out, finish, fetch_drop;

  // completion / timeout decode and the same-cycle response pulses
  always_comb begin
    busy       = (state_q != IDLE);
    beat_done  = busy & bus_ready;
    // the current cycle is the TIMEOUT-th one without ready
    timed_out  = busy & ~bus_ready & (cnt_q == CNT_LAST);
    finish     = beat_done | timed_out;
    // a redirect seen during the beat or on its last cycle kills the word
    fetch_drop = discard_q | flush_fetch;
    if_valid   = (state_q == FETCH) & finish & ~fetch_drop;
    dm_valid   = (state_q == DATA)  & finish;
    // timeout returns zero so the consumer never sees stale bus data
    if_rdata   = beat_done ? bus_rdata : '0;
    dm_rdata   = beat_done ? bus_rdata : '0;
  end

  // memory-wait stalls; a D bubble only when the back end is moving
  always_comb begin
    stall_back  = dm_req & ~dm_valid;
    stall_front = stall_back | (if_req & ~if_valid);
    flush_D     = if_req & ~if_valid & ~stall_back;
  end

  // arbitration and beat sequencing
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        discard_d = 1'b0;
        if (dm_req) begin
          state_d     = DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = dm_we;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          bus_wstrb_d = dm_wstrb;
        end else if (if_req && !flush_fetch) begin
          state_d     = FETCH;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wstrb_d = '0;
        end
      end
      FETCH, DATA: begin
        if (finish) begin
          // always one IDLE cycle so a not-yet-dropped req is not reissued
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          discard_d = 1'b0;
          err_d     = err_q | timed_out;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (state_q == FETCH && flush_fetch) discard_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // state and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter, checked cycle by cycle against a
// transaction-level model of the arbitration, timeout and stall rules.
module tb_mem_port_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_valid, flush_fetch;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [SW-1:0] dm_wstrb;
  logic          bus_req, bus_we, bus_ready;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [SW-1:0] bus_wstrb;
  logic          stall_front, stall_back, flush_D, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .flush_fetch(flush_fetch),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .stall_front(stall_front), .stall_back(stall_back), .flush_D(flush_D),
    .bus_err(bus_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // model: the beat currently owning the bus, if any
  int            m_own;      // 0 none, 1 fetch, 2 data
  int            m_waited;   // cycles of this beat spent without ready
  bit            m_drop;     // fetch result already redirected away
  bit            m_err;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;

  // what the requesters saw last cycle, to decide holding / re-issuing
  bit prev_ifv, prev_dmv, prev_flush, prev_rst;
  int n_tmo, n_drop, n_rst, n_ifv, n_dmv;

  task automatic model_reset();
    m_own = 0; m_waited = 0; m_drop = 0; m_err = 0;
    m_we = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  // one cycle: drive stimulus after the edge, check at negedge, advance model
  task automatic step(input int p_ready, input int p_flush, input int p_rst);
    bit done, tmo, ifv, dmv, sb;
    logic [DW-1:0] rd;
    @(posedge clk); #1;
    rst = ($urandom_range(99) < p_rst);
    if (prev_rst) begin
      if_req = 0; dm_req = 0;
    end
    if (!(if_req && !prev_ifv)) begin
      if_req  = ($urandom_range(99) < 60);
      if_addr = {32'h0, $urandom} & ~64'h3;
    end else if (prev_flush) begin
      if_addr = {32'h0, $urandom} & ~64'h3;   // redirect to a new PC
    end
    if (!(dm_req && !prev_dmv)) begin
      dm_req   = ($urandom_range(99) < 40);
      dm_we    = $urandom_range(1);
      dm_addr  = {$urandom, $urandom};
      dm_wdata = {$urandom, $urandom};
      dm_wstrb = SW'($urandom);
    end
    flush_fetch = ($urandom_range(99) < p_flush);
    bus_ready   = ($urandom_range(99) < p_ready);
    bus_rdata   = {$urandom, $urandom};
    @(negedge clk);

    done = (m_own != 0) && bus_ready;
    tmo  = (m_own != 0) && !bus_ready && (m_waited + 1 == TMO);
    ifv  = (m_own == 1) && (done || tmo) && !(m_drop || flush_fetch);
    dmv  = (m_own == 2) && (done || tmo);
    rd   = done ? bus_rdata : '0;
    sb   = dm_req && !dmv;

    chk("bus_req", bus_req, (m_own != 0));
    if (m_own != 0) begin
      chk("bus_we", bus_we, m_we);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wstrb", bus_wstrb, m_wstrb);
      if (m_own == 2 && m_we) chk("bus_wdata", bus_wdata, m_wdata);
    end
    chk("if_valid", if_valid, ifv);
    chk("dm_valid", dm_valid, dmv);
    if (ifv) chk("if_rdata", if_rdata, rd);
    if (dmv && !m_we) chk("dm_rdata", dm_rdata, rd);
    chk("stall_back", stall_back, sb);
    chk("stall_front", stall_front, sb || (if_req && !ifv));
    chk("flush_D", flush_D, if_req && !ifv && !sb);
    chk("bus_err", bus_err, m_err);

    if (tmo) n_tmo++;
    if ((m_own == 1) && (done || tmo) && !ifv) n_drop++;
    if (rst) n_rst++;
    if (ifv) n_ifv++;
    if (dmv) n_dmv++;
    prev_ifv = ifv; prev_dmv = dmv; prev_flush = flush_fetch; prev_rst = rst;

    if (rst) model_reset();
    else if (m_own != 0) begin
      if (done || tmo) begin
        m_own = 0; m_waited = 0; m_drop = 0;
        if (tmo) m_err = 1;
      end else begin
        m_waited++;
        if (m_own == 1 && flush_fetch) m_drop = 1;
      end
    end else if (dm_req) begin
      m_own = 2; m_waited = 0; m_drop = 0;
      m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
    end else if (if_req && !flush_fetch) begin
      m_own = 1; m_waited = 0; m_drop = 0;
      m_we = 0; m_addr = if_addr; m_wstrb = '0;
    end
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = '0; flush_fetch = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    bus_ready = 0; bus_rdata = {$urandom, $urandom};
    prev_ifv = 0; prev_dmv = 0; prev_flush = 0; prev_rst = 1;
    n_tmo = 0; n_drop = 0; n_rst = 0; n_ifv = 0; n_dmv = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, '0);
    chk("rst_bus_wdata", bus_wdata, '0);
    chk("rst_bus_wstrb", bus_wstrb, '0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_dm_valid", dm_valid, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);

    // responsive bus, occasional redirects and resets
    for (int i = 0; i < 600; i++) step(70, 5, 1);
    // slow bus: frequent timeouts, sticky error
    for (int i = 0; i < 600; i++) step(15, 5, 1);
    // redirect-heavy fetch traffic
    for (int i = 0; i < 600; i++) step(45, 30, 2);
    // fast bus, no resets: back-to-back completions with one IDLE gap
    for (int i = 0; i < 400; i++) step(95, 3, 0);

    $display("coverage: timeouts=%0d dropped_fetches=%0d resets=%0d if_done=%0d dm_done=%0d",
             n_tmo, n_drop, n_rst, n_ifv, n_dmv);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
